// File: rtl/bit_serializer_pkg.sv
// Shared types and defaults for the bit_serializer block.
package bit_serializer_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  localparam int   DEF_WIDTH      = 8;
  localparam logic DEF_IDLE_LEVEL = 1'b0;
endpackage

// File: rtl/ser_shift_core.sv
// Loadable shift register with bit counter; reports the bit that will be on the
// line after the coming edge plus last/next-to-last flags.
module ser_shift_core #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_head_nxt,
  output logic             o_last,
  output logic             o_pre_last
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_sreg <= i_din;
      r_cnt  <= CW'(WIDTH - 1);
    end else if (i_shift) begin
      r_sreg <= MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0} : {1'b0, r_sreg[WIDTH-1:1]};
      r_cnt  <= r_cnt - CW'(1);
    end
  end

  // Only meaningful when the caller loads or shifts on this edge.
  always_comb begin
    if (i_load) o_head_nxt = MSB_FIRST ? i_din[WIDTH-1] : i_din[0];
    else        o_head_nxt = MSB_FIRST ? r_sreg[WIDTH-2] : r_sreg[1];
  end

  assign o_last     = (r_cnt == '0);
  assign o_pre_last = (r_cnt == CW'(1));
endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder with valid/ready input and registered serial outputs.
// Optional trailing even-parity bit when BIT_SERIALIZER_PARITY_EN is defined.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WIDTH      = DEF_WIDTH,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             word_done
);
  state_t r_state, w_state_n;
  logic   w_load, w_shift, w_head_nxt, w_last, w_pre_last;
  logic   w_out_n, w_done_n;

  ser_shift_core #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_core (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_din      (din),
    .o_head_nxt (w_head_nxt),
    .o_last     (w_last),
    .o_pre_last (w_pre_last)
  );

`ifdef BIT_SERIALIZER_PARITY_EN
  logic r_par;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_par <= 1'b0;
    else if (w_load) r_par <= ^din;
  end
  assign din_ready = (r_state == IDLE) || (r_state == PAR);
`else
  assign din_ready = (r_state == IDLE) || ((r_state == SHIFT) && w_last);
`endif

  always_comb begin
    w_state_n = r_state;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    case (r_state)
      IDLE: if (din_valid) begin
        w_load    = 1'b1;
        w_state_n = SHIFT;
      end
      SHIFT: begin
        if (!w_last) begin
          w_shift = 1'b1;
        end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
          w_state_n = PAR;
`else
          // Chain straight into the next word so no idle gap appears on the line.
          w_load    = din_valid;
          w_state_n = din_valid ? SHIFT : IDLE;
`endif
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      PAR: begin
        w_load    = din_valid;
        w_state_n = din_valid ? SHIFT : IDLE;
      end
`endif
      default: w_state_n = IDLE;
    endcase
  end

  always_comb begin
    w_out_n = IDLE_LEVEL;
    case (w_state_n)
      SHIFT:   w_out_n = w_head_nxt;
`ifdef BIT_SERIALIZER_PARITY_EN
      PAR:     w_out_n = r_par;
`endif
      default: w_out_n = IDLE_LEVEL;
    endcase
`ifdef BIT_SERIALIZER_PARITY_EN
    w_done_n = (w_state_n == PAR);
`else
    w_done_n = w_shift && w_pre_last;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      out       <= IDLE_LEVEL;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      out       <= w_out_n;
      out_valid <= (w_state_n != IDLE);
      busy      <= (w_state_n != IDLE);
      word_done <= w_done_n;
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an MSB-first and an LSB-first instance share inputs.
module tb_bit_serializer;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  typedef struct {
    logic [7:0] din;
    logic [7:0] msb_seq;  // bit 7 is the first bit on the line
    logic [7:0] lsb_seq;
    logic       par;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready, out, out_valid, busy, word_done;
  logic       l_ready, l_out, l_valid, l_busy, l_done;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .out(out), .out_valid(out_valid), .busy(busy), .word_done(word_done));

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(l_ready),
    .out(l_out), .out_valid(l_valid), .busy(l_busy), .word_done(l_done));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " out"}, 32'(out), 32'(1'b0));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(1'b0));
    chk({tag, " busy"}, 32'(busy), 32'(1'b0));
    chk({tag, " word_done"}, 32'(word_done), 32'(1'b0));
    chk({tag, " din_ready"}, 32'(din_ready), 32'(1'b1));
    chk({tag, " lsb out_valid"}, 32'(l_valid), 32'(1'b0));
  endtask

  // Entered just after a posedge with the block idle.
  task automatic run_word(input rec_t r, input int idx);
    string t;
    logic  em, el;
    t = $sformatf("vec%0d", idx);
    din = r.din;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int j = 0; j < NB; j++) begin
      @(negedge clk);
      em = (j < 8) ? r.msb_seq[7-j] : r.par;
      el = (j < 8) ? r.lsb_seq[7-j] : r.par;
      chk($sformatf("%s bit%0d out", t, j), 32'(out), 32'(em));
      chk($sformatf("%s bit%0d lsb out", t, j), 32'(l_out), 32'(el));
      chk($sformatf("%s bit%0d out_valid", t, j), 32'(out_valid), 32'(1'b1));
      chk($sformatf("%s bit%0d busy", t, j), 32'(busy), 32'(1'b1));
      chk($sformatf("%s bit%0d word_done", t, j), 32'(word_done), 32'(j == NB-1));
      chk($sformatf("%s bit%0d din_ready", t, j), 32'(din_ready), 32'(j == NB-1));
    end
    @(negedge clk);
    chk_idle({t, " after"});
    @(posedge clk); #1;
  endtask

  rec_t vec [6];

  initial begin
    logic [15:0] bb_m, bb_l;
    logic [1:0]  bb_p;
    logic        em, el;
    int          w, j;
    rec_t        r;

    vec[0] = '{din: 8'hB0, msb_seq: 8'hB0, lsb_seq: 8'h0D, par: 1'b1};
    vec[1] = '{din: 8'h0D, msb_seq: 8'h0D, lsb_seq: 8'hB0, par: 1'b1};
    vec[2] = '{din: 8'hB1, msb_seq: 8'hB1, lsb_seq: 8'h8D, par: 1'b0};
    vec[3] = '{din: 8'hFF, msb_seq: 8'hFF, lsb_seq: 8'hFF, par: 1'b0};
    vec[4] = '{din: 8'h01, msb_seq: 8'h01, lsb_seq: 8'h80, par: 1'b1};
    vec[5] = '{din: 8'h80, msb_seq: 8'h80, lsb_seq: 8'h01, par: 1'b1};

    reset = 1'b0;
    din = 8'h00;
    din_valid = 1'b0;
    #12;
    chk_idle("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_word(vec[i], i);

    // Back-to-back 0B then 80 with valid held: contiguous bits, no gap.
    bb_m = 16'h0B80;
    bb_l = 16'hD001;
    bb_p = 2'b11;
    din = 8'h0B;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din = 8'h80;
    for (int i = 0; i < 2*NB; i++) begin
      @(negedge clk);
      w = i / NB;
      j = i % NB;
      em = (j < 8) ? bb_m[15 - (w*8 + j)] : bb_p[w];
      el = (j < 8) ? bb_l[15 - (w*8 + j)] : bb_p[w];
      chk($sformatf("b2b bit%0d out", i), 32'(out), 32'(em));
      chk($sformatf("b2b bit%0d lsb out", i), 32'(l_out), 32'(el));
      chk($sformatf("b2b bit%0d out_valid", i), 32'(out_valid), 32'(1'b1));
      chk($sformatf("b2b bit%0d word_done", i), 32'(word_done), 32'(j == NB-1));
      chk($sformatf("b2b bit%0d din_ready", i), 32'(din_ready), 32'(j == NB-1));
      if (i == NB-1) begin
        @(posedge clk); #1;
        din_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk_idle("b2b after");
    @(posedge clk); #1;

    // Valid held with changing din while shifting: no extra accept.
    din = 8'hB0;
    din_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      em = (i < 8) ? vec[0].msb_seq[7-i] : vec[0].par;
      chk($sformatf("hold bit%0d out", i), 32'(out), 32'(em));
      chk($sformatf("hold bit%0d out_valid", i), 32'(out_valid), 32'(1'b1));
      if (i < NB-1) din = 8'($urandom_range(0, 255));
      else          din_valid = 1'b0;
    end
    @(negedge clk);
    chk_idle("hold after");
    @(posedge clk); #1;

    // Reset mid-word after three bits of FF.
    din = 8'hFF;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst bit%0d out", i), 32'(out), 32'(1'b1));
    end
    reset = 1'b0;
    #1;
    chk_idle("midreset");
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post reset din_ready", 32'(din_ready), 32'(1'b1));
    r = vec[4];
    run_word(r, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
